// File: rtl/dma_dscrptr_load_ctrl.sv
// Descriptor load controller: fetches one internal buffer descriptor from the bank,
// validates it and offers it to the transfer engine, or reports it as invalid.
module dma_dscrptr_load_ctrl #(
    parameter int NUM_INT_BDS       = 4,
    parameter int NUM_INT_BDS_WIDTH = 2,
    parameter int BYTE_CNT_WIDTH    = 23
) (
    input  logic                         clock,
    input  logic                         resetn,
    input  logic                         ldDscrptr,
    input  logic [NUM_INT_BDS_WIDTH-1:0] ldDscrptrNum,
    output logic                         ldIntDscrptrAck,
    output logic                         dscrptrRdEn,
    output logic [NUM_INT_BDS_WIDTH-1:0] dscrptrRdAddr,
    input  logic [31:0]                  dscrptrRdCfg,
    input  logic [31:0]                  dscrptrRdSrcAddr,
    input  logic [31:0]                  dscrptrRdDstAddr,
    input  logic [BYTE_CNT_WIDTH-1:0]    dscrptrRdByteCnt,
    output logic                         xferValid,
    input  logic                         xferReady,
    output logic [NUM_INT_BDS_WIDTH-1:0] xferDscrptrNum,
    output logic [31:0]                  xferCfg,
    output logic [31:0]                  xferSrcAddr,
    output logic [31:0]                  xferDstAddr,
    output logic [BYTE_CNT_WIDTH-1:0]    xferByteCnt,
    output logic                         invldDscrptr,
    output logic [NUM_INT_BDS_WIDTH-1:0] invldDscrptrNum,
    output logic                         busy
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CHECK,
        ISSUE,
        GUARD
    } state_t;

    localparam logic [NUM_INT_BDS_WIDTH:0] NUM_BDS_EXT = NUM_INT_BDS[NUM_INT_BDS_WIDTH:0];

    state_t                       state;
    logic [NUM_INT_BDS_WIDTH-1:0] index;
    logic                         index_oob;
    logic                         dscrptr_bad;

    // Index range check is only meaningful when NUM_INT_BDS is not a power of two.
    assign index_oob   = ({1'b0, index} >= NUM_BDS_EXT);
    assign dscrptr_bad = ~dscrptrRdCfg[0] | (dscrptrRdByteCnt == '0) | index_oob;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state           <= IDLE;
            index           <= '0;
            ldIntDscrptrAck <= 1'b0;
            dscrptrRdEn     <= 1'b0;
            dscrptrRdAddr   <= '0;
            xferValid       <= 1'b0;
            xferDscrptrNum  <= '0;
            xferCfg         <= '0;
            xferSrcAddr     <= '0;
            xferDstAddr     <= '0;
            xferByteCnt     <= '0;
            invldDscrptr    <= 1'b0;
            invldDscrptrNum <= '0;
            busy            <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ldDscrptr) begin
                        index         <= ldDscrptrNum;
                        dscrptrRdEn   <= 1'b1;
                        dscrptrRdAddr <= ldDscrptrNum;
                        busy          <= 1'b1;
                        state         <= READ;
                    end
                end
                READ: begin
                    dscrptrRdEn   <= 1'b0;
                    dscrptrRdAddr <= '0;
                    state         <= CHECK;
                end
                CHECK: begin
                    // Bank data is valid now; capture it so xfer* stay stable while offered.
                    xferDscrptrNum <= index;
                    xferCfg        <= dscrptrRdCfg;
                    xferSrcAddr    <= dscrptrRdSrcAddr;
                    xferDstAddr    <= dscrptrRdDstAddr;
                    xferByteCnt    <= dscrptrRdByteCnt;
                    if (dscrptr_bad) begin
                        ldIntDscrptrAck <= 1'b1;
                        invldDscrptr    <= 1'b1;
                        invldDscrptrNum <= index;
                        state           <= GUARD;
                    end else begin
                        xferValid <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (xferReady) begin
                        xferValid       <= 1'b0;
                        ldIntDscrptrAck <= 1'b1;
                        state           <= GUARD;
                    end
                end
                GUARD: begin
                    ldIntDscrptrAck <= 1'b0;
                    invldDscrptr    <= 1'b0;
                    invldDscrptrNum <= '0;
                    busy            <= 1'b0;
                    state           <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_dscrptr_load_ctrl.sv
// Scoreboard bench for dma_dscrptr_load_ctrl: a stimulus process pushes predicted
// outcomes from a descriptor bank model, a negedge monitor pops and compares them.
module tb_dma_dscrptr_load_ctrl;

    localparam int NB = 4;
    localparam int NW = 2;
    localparam int BW = 23;

    logic          clock = 1'b0;
    logic          resetn;
    logic          ldDscrptr;
    logic [NW-1:0] ldDscrptrNum;
    logic          ldIntDscrptrAck;
    logic          dscrptrRdEn;
    logic [NW-1:0] dscrptrRdAddr;
    logic [31:0]   rd_cfg = '0;
    logic [31:0]   rd_src = '0;
    logic [31:0]   rd_dst = '0;
    logic [BW-1:0] rd_cnt = '0;
    logic          xferValid;
    logic          xferReady;
    logic [NW-1:0] xferDscrptrNum;
    logic [31:0]   xferCfg;
    logic [31:0]   xferSrcAddr;
    logic [31:0]   xferDstAddr;
    logic [BW-1:0] xferByteCnt;
    logic          invldDscrptr;
    logic [NW-1:0] invldDscrptrNum;
    logic          busy;

    always #5 clock = ~clock;

    dma_dscrptr_load_ctrl #(
        .NUM_INT_BDS      (NB),
        .NUM_INT_BDS_WIDTH(NW),
        .BYTE_CNT_WIDTH   (BW)
    ) dut (
        .clock           (clock),
        .resetn          (resetn),
        .ldDscrptr       (ldDscrptr),
        .ldDscrptrNum    (ldDscrptrNum),
        .ldIntDscrptrAck (ldIntDscrptrAck),
        .dscrptrRdEn     (dscrptrRdEn),
        .dscrptrRdAddr   (dscrptrRdAddr),
        .dscrptrRdCfg    (rd_cfg),
        .dscrptrRdSrcAddr(rd_src),
        .dscrptrRdDstAddr(rd_dst),
        .dscrptrRdByteCnt(rd_cnt),
        .xferValid       (xferValid),
        .xferReady       (xferReady),
        .xferDscrptrNum  (xferDscrptrNum),
        .xferCfg         (xferCfg),
        .xferSrcAddr     (xferSrcAddr),
        .xferDstAddr     (xferDstAddr),
        .xferByteCnt     (xferByteCnt),
        .invldDscrptr    (invldDscrptr),
        .invldDscrptrNum (invldDscrptrNum),
        .busy            (busy)
    );

    logic [31:0]   bank_cfg [NB];
    logic [31:0]   bank_src [NB];
    logic [31:0]   bank_dst [NB];
    logic [BW-1:0] bank_cnt [NB];

    // Descriptor bank model: read data appears the cycle after the read strobe.
    always @(posedge clock) begin
        if (dscrptrRdEn) begin
            rd_cfg <= bank_cfg[dscrptrRdAddr];
            rd_src <= bank_src[dscrptrRdAddr];
            rd_dst <= bank_dst[dscrptrRdAddr];
            rd_cnt <= bank_cnt[dscrptrRdAddr];
        end
    end

    typedef struct {
        bit            invalid;
        logic [NW-1:0] num;
        logic [31:0]   cfg;
        logic [31:0]   src;
        logic [31:0]   dst;
        logic [BW-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic exp_t predict(input int num);
        exp_t e;
        e.num     = num[NW-1:0];
        e.cfg     = bank_cfg[num];
        e.src     = bank_src[num];
        e.dst     = bank_dst[num];
        e.cnt     = bank_cnt[num];
        e.invalid = (bank_cfg[num][0] == 1'b0) || (bank_cnt[num] == 0) || (num >= NB);
        return e;
    endfunction

    // Monitor: pops one prediction per offered descriptor or invalid report.
    exp_t          mon_e;
    logic          prev_hs = 1'b0;
    logic          prev_stall = 1'b0;
    logic [NW-1:0] p_num;
    logic [31:0]   p_cfg, p_src, p_dst;
    logic [BW-1:0] p_cnt;

    always @(negedge clock) begin
        if (!resetn) begin
            prev_hs    = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checkOutput("stall_valid", xferValid, 1'b1);
                checkOutput("stall_num_cfg", {xferDscrptrNum, xferCfg}, {p_num, p_cfg});
                checkOutput("stall_src", xferSrcAddr, p_src);
                checkOutput("stall_dst", xferDstAddr, p_dst);
                checkOutput("stall_cnt", xferByteCnt, p_cnt);
            end
            if (ldIntDscrptrAck || prev_hs || invldDscrptr)
                checkOutput("ack_timing", ldIntDscrptrAck, prev_hs || invldDscrptr);
            if ((xferValid && xferReady) || invldDscrptr) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_output: valid=%0b invld=%0b with nothing pending",
                             xferValid, invldDscrptr);
                end else begin
                    mon_e = exp_q.pop_front();
                    checkOutput("result_kind", invldDscrptr, mon_e.invalid);
                    if (invldDscrptr) begin
                        checkOutput("invld_num", invldDscrptrNum, mon_e.num);
                        checkOutput("invld_no_valid", xferValid, 1'b0);
                    end else begin
                        checkOutput("xfer_num", xferDscrptrNum, mon_e.num);
                        checkOutput("xfer_cfg", xferCfg, mon_e.cfg);
                        checkOutput("xfer_src", xferSrcAddr, mon_e.src);
                        checkOutput("xfer_dst", xferDstAddr, mon_e.dst);
                        checkOutput("xfer_cnt", xferByteCnt, mon_e.cnt);
                    end
                end
            end
            prev_hs    = xferValid && xferReady;
            prev_stall = xferValid && !xferReady;
            p_num      = xferDscrptrNum;
            p_cfg      = xferCfg;
            p_src      = xferSrcAddr;
            p_dst      = xferDstAddr;
            p_cnt      = xferByteCnt;
        end
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50) begin
            next_cycle();
            n++;
        end
        if (busy) checkOutput("idle_timeout", busy, 1'b0);
    endtask

    task automatic set_bd(input int i, input logic [31:0] cfg, input logic [31:0] src,
                          input logic [31:0] dst, input logic [BW-1:0] cnt);
        bank_cfg[i] = cfg;
        bank_src[i] = src;
        bank_dst[i] = dst;
        bank_cnt[i] = cnt;
    endtask

    task automatic randomize_bank();
        for (int i = 0; i < NB; i++) begin
            bank_cfg[i]    = $urandom;
            bank_cfg[i][0] = ($urandom_range(0, 3) != 0);
            bank_src[i]    = $urandom;
            bank_dst[i]    = $urandom;
            bank_cnt[i]    = ($urandom_range(0, 5) == 0) ? '0 : BW'($urandom);
        end
    endtask

    task automatic wait_ack(input string name);
        bit got = 0;
        for (int n = 0; n < 60 && !got; n++) begin
            next_cycle();
            got = ldIntDscrptrAck;
        end
        if (!got) checkOutput(name, got, 1'b1);
    endtask

    // One request; ready is random or tied high, and the index input wanders after acceptance.
    task automatic applyStimulus(input int num, input bit always_ready);
        bit got = 0;
        wait_idle();
        exp_q.push_back(predict(num));
        ldDscrptr    = 1'b1;
        ldDscrptrNum = num[NW-1:0];
        next_cycle();
        ldDscrptr = 1'b0;
        for (int n = 0; n < 60 && !got; n++) begin
            ldDscrptrNum = NW'($urandom);
            xferReady    = always_ready ? 1'b1 : 1'($urandom_range(0, 1));
            next_cycle();
            got = ldIntDscrptrAck;
        end
        xferReady = 1'b0;
        if (!got) checkOutput("ack_timeout", got, 1'b1);
    endtask

    task automatic run_invalid(input int num);
        wait_idle();
        exp_q.push_back(predict(num));
        ldDscrptr    = 1'b1;
        ldDscrptrNum = num[NW-1:0];
        next_cycle();
        ldDscrptr = 1'b0;
        checkOutput("invld_ack_n1", ldIntDscrptrAck, 1'b0);
        next_cycle();
        checkOutput("invld_ack_n2", ldIntDscrptrAck, 1'b0);
        next_cycle();
        checkOutput("invld_ack_n3", ldIntDscrptrAck, 1'b1);
        checkOutput("invld_flag_n3", invldDscrptr, 1'b1);
        checkOutput("invld_num_n3", invldDscrptrNum, num);
        checkOutput("invld_valid_n3", xferValid, 1'b0);
        next_cycle();
        checkOutput("invld_flag_n4", invldDscrptr, 1'b0);
        checkOutput("invld_ack_n4", ldIntDscrptrAck, 1'b0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetn       = 1'b0;
        ldDscrptr    = 1'b0;
        ldDscrptrNum = '0;
        xferReady    = 1'b0;
        randomize_bank();
        #1;
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_valid", xferValid, 1'b0);
        checkOutput("reset_ack", ldIntDscrptrAck, 1'b0);
        checkOutput("reset_rden", dscrptrRdEn, 1'b0);
        checkOutput("reset_invld", invldDscrptr, 1'b0);
        repeat (2) next_cycle();

        // Reset release together with a request: accepted on the very first edge.
        set_bd(2, 32'h1, 32'h1000, 32'h2000, BW'(64));
        exp_q.push_back(predict(2));
        xferReady    = 1'b1;
        resetn       = 1'b1;
        ldDscrptr    = 1'b1;
        ldDscrptrNum = 2'd2;
        next_cycle();
        checkOutput("rd_en_n1", dscrptrRdEn, 1'b1);
        checkOutput("rd_addr_n1", dscrptrRdAddr, 2);
        checkOutput("busy_n1", busy, 1'b1);
        ldDscrptr = 1'b0;
        next_cycle();
        checkOutput("valid_n2", xferValid, 1'b0);
        checkOutput("rd_en_n2", dscrptrRdEn, 1'b0);
        next_cycle();
        checkOutput("valid_n3", xferValid, 1'b1);
        checkOutput("num_n3", xferDscrptrNum, 2);
        checkOutput("src_n3", xferSrcAddr, 32'h1000);
        checkOutput("dst_n3", xferDstAddr, 32'h2000);
        checkOutput("cnt_n3", xferByteCnt, 64);
        next_cycle();
        checkOutput("ack_n4", ldIntDscrptrAck, 1'b1);
        checkOutput("valid_n4", xferValid, 1'b0);
        next_cycle();
        checkOutput("busy_n5", busy, 1'b0);
        checkOutput("ack_n5", ldIntDscrptrAck, 1'b0);
        xferReady = 1'b0;

        // Transfer engine stalls for five cycles.
        set_bd(3, 32'h8000_0011, 32'hCAFE_0000, 32'hBEEF_0000, BW'(23'h7FFFFF));
        exp_q.push_back(predict(3));
        ldDscrptr    = 1'b1;
        ldDscrptrNum = 2'd3;
        next_cycle();
        ldDscrptr = 1'b0;
        next_cycle();
        next_cycle();
        for (int k = 0; k < 6; k++) begin
            checkOutput("stall_hold_valid", xferValid, 1'b1);
            checkOutput("stall_hold_src", xferSrcAddr, 32'hCAFE_0000);
            checkOutput("stall_no_ack", ldIntDscrptrAck, 1'b0);
            if (k == 5) xferReady = 1'b1;
            next_cycle();
        end
        checkOutput("stall_ack", ldIntDscrptrAck, 1'b1);
        checkOutput("stall_valid_drop", xferValid, 1'b0);
        xferReady = 1'b0;
        next_cycle();
        checkOutput("stall_ack_once", ldIntDscrptrAck, 1'b0);

        // Invalid descriptors: config valid bit clear, then zero byte count.
        set_bd(1, 32'h0000_0F00, 32'h11, 32'h22, BW'(5));
        run_invalid(1);
        set_bd(1, 32'h0000_0001, 32'h11, 32'h22, '0);
        run_invalid(1);

        // Request held high across the ack while the index changes 0 -> 3.
        wait_idle();
        set_bd(0, 32'h3, 32'hA0, 32'hB0, BW'(8));
        set_bd(3, 32'h5, 32'hC0, 32'hD0, BW'(16));
        exp_q.push_back(predict(0));
        exp_q.push_back(predict(3));
        xferReady    = 1'b1;
        ldDscrptr    = 1'b1;
        ldDscrptrNum = 2'd0;
        wait_ack("b2b_first_ack");
        ldDscrptrNum = 2'd3;
        next_cycle();
        checkOutput("b2b_idle_gap_busy", busy, 1'b0);
        checkOutput("b2b_idle_gap_rden", dscrptrRdEn, 1'b0);
        next_cycle();
        checkOutput("b2b_second_rden", dscrptrRdEn, 1'b1);
        checkOutput("b2b_second_addr", dscrptrRdAddr, 3);
        ldDscrptr = 1'b0;
        wait_ack("b2b_second_ack");
        xferReady = 1'b0;

        // Index input changes during READ; the captured index must win.
        wait_idle();
        set_bd(1, 32'h7, 32'h1234, 32'h5678, BW'(99));
        exp_q.push_back(predict(1));
        ldDscrptr    = 1'b1;
        ldDscrptrNum = 2'd1;
        next_cycle();
        ldDscrptr    = 1'b0;
        ldDscrptrNum = 2'd3;
        checkOutput("read_addr_held", dscrptrRdAddr, 1);
        xferReady = 1'b1;
        wait_ack("num_change_ack");
        xferReady = 1'b0;

        // Reset while a descriptor is being offered.
        wait_idle();
        set_bd(2, 32'h9, 32'h4444, 32'h5555, BW'(12));
        exp_q.push_back(predict(2));
        ldDscrptr    = 1'b1;
        ldDscrptrNum = 2'd2;
        next_cycle();
        ldDscrptr = 1'b0;
        next_cycle();
        next_cycle();
        checkOutput("pre_reset_valid", xferValid, 1'b1);
        resetn = 1'b0;
        #1;
        checkOutput("rst_valid", xferValid, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_src", xferSrcAddr, 0);
        checkOutput("rst_num", xferDscrptrNum, 0);
        checkOutput("rst_cnt", xferByteCnt, 0);
        exp_q.delete();
        next_cycle();
        checkOutput("rst_no_ack", ldIntDscrptrAck, 1'b0);
        next_cycle();
        resetn = 1'b1;
        applyStimulus(2, 1'b1);

        repeat (40) begin
            wait_idle();
            randomize_bank();
            applyStimulus($urandom_range(0, NB - 1), 1'b0);
        end

        repeat (4) next_cycle();
        checkOutput("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dma_dscrptr_load_ctrl.md
DMA_DSCRPTR_LOAD_CTRL -- requirements
Module: dma_dscrptr_load_ctrl

Interface
REQ-001 SHALL have parameter NUM_INT_BDS, default 4, number of internal buffer descriptors.
REQ-002 SHALL have parameter NUM_INT_BDS_WIDTH, default 2, width of descriptor index.
REQ-003 SHALL have parameter BYTE_CNT_WIDTH, default 23, width of transfer byte count.
REQ-004 clock  in  1  single clock; all logic on rising edge.
REQ-005 resetn  in  1  reset, asynchronous assert, active-low.
REQ-006 ldDscrptr  in  1  load request from start arbiter; held high until acked.
REQ-007 ldDscrptrNum  in  NUM_INT_BDS_WIDTH  index of descriptor to load.
REQ-008 ldIntDscrptrAck  out  1  one-cycle acknowledge of the request.
REQ-009 dscrptrRdEn  out  1  descriptor bank read strobe.
REQ-010 dscrptrRdAddr  out  NUM_INT_BDS_WIDTH  descriptor bank read index.
REQ-011 dscrptrRdCfg  in  32  read data, config word; bit0 = descriptor valid.
REQ-012 dscrptrRdSrcAddr / dscrptrRdDstAddr  in  32 each  read data, source/destination address.
REQ-013 dscrptrRdByteCnt  in  BYTE_CNT_WIDTH  read data, byte count.
REQ-014 xferValid  out  1  loaded descriptor offered to transfer engine.
REQ-015 xferReady  in  1  transfer engine accepts descriptor.
REQ-016 xferDscrptrNum, xferCfg, xferSrcAddr, xferDstAddr, xferByteCnt  out  NUM_INT_BDS_WIDTH/32/32/32/BYTE_CNT_WIDTH  registered descriptor fields.
REQ-017 invldDscrptr  out  1  one-cycle pulse: request rejected; invldDscrptrNum  out  NUM_INT_BDS_WIDTH  its index.
REQ-018 busy  out  1  high in every state except IDLE.

Function
REQ-019 SHALL implement FSM IDLE, READ, CHECK, ISSUE, GUARD; one request in flight.
REQ-020 IDLE: ldDscrptr=1 at edge -> capture ldDscrptrNum into index register, go READ.
REQ-021 READ (one cycle): dscrptrRdEn=1, dscrptrRdAddr=captured index; -> CHECK.
REQ-022 Bank read data valid in cycle after dscrptrRdEn; CHECK SHALL register all read fields at end of CHECK.
REQ-023 CHECK: descriptor invalid if dscrptrRdCfg[0]=0, dscrptrRdByteCnt=0, or index >= NUM_INT_BDS; invalid -> GUARD with error flagged; valid -> ISSUE.
REQ-024 ISSUE: xferValid=1; all xfer* outputs stable until xferValid&&xferReady; handshake -> GUARD.
REQ-025 xferReady=1 on first ISSUE cycle SHALL complete handshake that cycle (ISSUE lasts one cycle).
REQ-026 GUARD (one cycle): ldIntDscrptrAck=1; if flagged invalid, invldDscrptr=1 and invldDscrptrNum=index; -> IDLE.
REQ-027 ldDscrptr SHALL be ignored in all states except IDLE, including GUARD; earliest next acceptance is the IDLE cycle after GUARD.
REQ-028 Minimum latency ldDscrptr sampled (edge N) -> xferValid: high in cycle N+3; ack in cycle after handshake.
REQ-029 Invalid path: ack and invldDscrptr in cycle N+3; xferValid never asserted.
REQ-030 ldDscrptr deasserting or ldDscrptrNum changing after acceptance SHALL not alter in-flight transaction.
REQ-031 xferValid SHALL never deassert without handshake except by reset.
REQ-032 ldIntDscrptrAck, invldDscrptr SHALL be exactly one cycle per accepted request.

Reset
REQ-033 resetn low SHALL immediately force IDLE and all outputs to 0 (xfer* data, index, flags included), mid-transaction included; pending transaction discarded, no ack.
REQ-034 First acceptance possible at first rising edge with resetn high.

Verification
REQ-035 ldDscrptr=1, num=2, bank[2]={cfg=1, src=0x1000, dst=0x2000, cnt=64}, xferReady=1 -> rdEn/rdAddr=2 at N+1, xferValid with those fields at N+3, ack at N+4, busy low N+5.
REQ-036 Same with xferReady=0 for 5 cycles -> xferValid held 6 cycles, fields stable, ack exactly one cycle after handshake.
REQ-037 bank[1].cfg=0 -> no xferValid; ack=1, invldDscrptr=1, invldDscrptrNum=1 at N+3; repeat with cnt=0 -> same.
REQ-038 ldDscrptr held high across ack with num 0 then 3 -> second acceptance only in IDLE after GUARD; two acks total, order 0 then 3.
REQ-039 resetn low during ISSUE -> xferValid, busy, all outputs 0 immediately; no ack; new request after release completes normally.
REQ-040 ldDscrptrNum changed from 1 to 3 during READ -> rdAddr and xferDscrptrNum stay 1.
